// File: rtl/score_pkg.sv
// Shared types and BCD helpers for the score bank.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package score_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    IDLE = 1'b0,
    INC  = 1'b1
  } score_state_e;

  // Widest score the compare helper handles; narrower scores are zero-padded.
  localparam int MAX_DIGITS  = 6;
  localparam int MAX_SCORE_W = 4 * MAX_DIGITS;

  // Increment one BCD digit by carry_in. Returns {digit, carry_out}.
  function automatic logic [4:0] bcd_inc(input bcd_digit_t digit, input logic carry_in);
    logic [4:0] r;
    r = {digit, 1'b0};
    if (carry_in) begin
      if (digit >= 4'd9) r = {4'd0, 1'b1};
      else               r = {digit + 4'd1, 1'b0};
    end
    return r;
  endfunction

  // Magnitude compare of two packed BCD scores, most significant digit first.
  function automatic logic bcd_gt(input logic [MAX_SCORE_W-1:0] a,
                                  input logic [MAX_SCORE_W-1:0] b);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
        gt      = (a[4*i +: 4] > b[4*i +: 4]);
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/score_bcd_chain.sv
// One player's NUM_DIGITS BCD ripple counter: +1 per inc cycle, clear, optional saturate.
// Latency: digits update on the edge inc is sampled; wrap pulses the cycle after the overflow edge.
// Backpressure: none; every inc is applied (or absorbed at all-9s when sat=1).
// Ports: clk, rst_n (sync, active low), clr (sync clear), inc, sat,
//        digits (ones in [3:0]), all_nines (combinational), wrap (1-cycle pulse).
module score_bcd_chain
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    inc,
  input  logic                    sat,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    all_nines,
  output logic                    wrap
);

  logic [4*NUM_DIGITS-1:0] nxt;
  logic                    carry_out;

  // Ripple carry through all digits in one cycle.
  always_comb begin
    logic       c;
    logic [4:0] r;
    nxt       = digits;
    all_nines = 1'b1;
    c         = inc;
    r         = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r              = bcd_inc(digits[4*i +: 4], c);
      nxt[4*i +: 4]  = r[4:1];
      c              = r[0];
      if (digits[4*i +: 4] != 4'd9) all_nines = 1'b0;
    end
    carry_out = c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      digits <= '0;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (inc) begin
        if (all_nines && sat) begin
          // Hold at all-9s but still report the overflow attempt.
          wrap <= 1'b1;
        end else begin
          digits <= nxt;
          wrap   <= carry_out;
        end
      end
    end
  end

endmodule

// File: rtl/score_bank.sv
// Multi-player BCD score store: adds a 0..15 point value one count per cycle to a chosen player.
// Latency: add of N completes N cycles after the request edge (fewer if saturating); hiscore 1 cycle.
// Backpressure: ADD_BUSY high while counting; ADD_REQ seen during ADD_BUSY is dropped, not queued.
// Ports: CLK_DRV, RESET_N (sync active low), START_GAME_N (clear scores), ADD_REQ/ADD_PLAYER/ADD_VAL,
//        ADD_BUSY, WRAP_PULSE, DISP_SEL/DISP_SCORE, SCORES, GAME_OVER, HISCORE.
// Optional: define SCORE_HISCORE_EN to enable the high-score register; otherwise HISCORE reads 0.
module score_bank
  import score_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_DIGITS  = 3,
  parameter bit SATURATE    = 1'b0,
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int SW = 4 * NUM_DIGITS
) (
  input  logic                      CLK_DRV,
  input  logic                      RESET_N,
  input  logic                      START_GAME_N,
  input  logic                      ADD_REQ,
  input  logic [PW-1:0]             ADD_PLAYER,
  input  logic [3:0]                ADD_VAL,
  output logic                      ADD_BUSY,
  output logic [NUM_PLAYERS-1:0]    WRAP_PULSE,
  input  logic [PW-1:0]             DISP_SEL,
  output logic [SW-1:0]             DISP_SCORE,
  output logic [SW*NUM_PLAYERS-1:0] SCORES,
  input  logic                      GAME_OVER,
  output logic [SW-1:0]             HISCORE
);

  localparam logic [PW:0] NP_W = (PW + 1)'(NUM_PLAYERS);

  score_state_e           state_q, state_d;
  logic [PW-1:0]          player_q, player_d;
  logic [3:0]             rem_q, rem_d;
  logic [NUM_PLAYERS-1:0] inc_vec;
  logic [NUM_PLAYERS-1:0] nines_vec;

  always_ff @(posedge CLK_DRV) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      player_q <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      rem_q    <= rem_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    rem_d    = rem_q;
    inc_vec  = '0;
    case (state_q)
      IDLE: begin
        if (ADD_REQ && (ADD_VAL != 4'd0) && ({1'b0, ADD_PLAYER} < NP_W)) begin
          player_d = ADD_PLAYER;
          rem_d    = ADD_VAL;
          state_d  = INC;
        end
      end
      INC: begin
        inc_vec[player_q] = 1'b1;
        rem_d             = rem_q - 4'd1;
        // Last count, or a saturating overflow that ends the add early.
        if ((rem_q == 4'd1) || (SATURATE && nines_vec[player_q])) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // New game wins over any request or count in progress.
    if (!START_GAME_N) begin
      state_d = IDLE;
      inc_vec = '0;
    end
  end

  assign ADD_BUSY = (state_q == INC);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    score_bcd_chain #(
      .NUM_DIGITS(NUM_DIGITS)
    ) u_chain (
      .clk      (CLK_DRV),
      .rst_n    (RESET_N),
      .clr      (!START_GAME_N),
      .inc      (inc_vec[p]),
      .sat      (SATURATE),
      .digits   (SCORES[p*SW +: SW]),
      .all_nines(nines_vec[p]),
      .wrap     (WRAP_PULSE[p])
    );
  end

  always_comb begin
    DISP_SCORE = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if ({1'b0, DISP_SEL} == (PW + 1)'(p)) DISP_SCORE = SCORES[p*SW +: SW];
    end
  end

`ifdef SCORE_HISCORE_EN
  logic [SW-1:0] hiscore_q;
  logic [SW-1:0] best;

  // Scores feeding this compare are the pre-edge values, so a concurrent count is not seen.
  always_comb begin
    best = hiscore_q;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (bcd_gt(MAX_SCORE_W'(SCORES[p*SW +: SW]), MAX_SCORE_W'(best)))
        best = SCORES[p*SW +: SW];
    end
  end

  always_ff @(posedge CLK_DRV) begin
    if (!RESET_N)       hiscore_q <= '0;
    else if (GAME_OVER) hiscore_q <= best;
  end

  assign HISCORE = hiscore_q;
`else
  logic unused_game_over;
  assign unused_game_over = GAME_OVER;
  assign HISCORE          = '0;
`endif

endmodule

// File: tb/tb_score_bank.sv
// Directed bench for score_bank: two instances share stimulus.
// dut_a: 3 players, wrapping. dut_b: 2 players, saturating.
module tb_score_bank;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_n, req_a, req_b, game_over;
  logic [1:0]  pa, sel_a;
  logic [0:0]  pb, sel_b;
  logic [3:0]  val;

  logic        busy_a, busy_b;
  logic [2:0]  wrap_a;
  logic [1:0]  wrap_b;
  logic [11:0] disp_a, disp_b, hi_a, hi_b;
  logic [35:0] scores_a;
  logic [23:0] scores_b;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

`ifdef SCORE_HISCORE_EN
  localparam logic [11:0] EXP_HI = 12'h340;
`else
  localparam logic [11:0] EXP_HI = 12'h000;
`endif

  score_bank #(.NUM_PLAYERS(3), .NUM_DIGITS(3), .SATURATE(1'b0)) dut_a (
    .CLK_DRV(clk), .RESET_N(rst_n), .START_GAME_N(start_n),
    .ADD_REQ(req_a), .ADD_PLAYER(pa), .ADD_VAL(val), .ADD_BUSY(busy_a),
    .WRAP_PULSE(wrap_a), .DISP_SEL(sel_a), .DISP_SCORE(disp_a),
    .SCORES(scores_a), .GAME_OVER(game_over), .HISCORE(hi_a)
  );

  score_bank #(.NUM_PLAYERS(2), .NUM_DIGITS(3), .SATURATE(1'b1)) dut_b (
    .CLK_DRV(clk), .RESET_N(rst_n), .START_GAME_N(start_n),
    .ADD_REQ(req_b), .ADD_PLAYER(pb), .ADD_VAL(val), .ADD_BUSY(busy_b),
    .WRAP_PULSE(wrap_b), .DISP_SEL(sel_b), .DISP_SCORE(disp_b),
    .SCORES(scores_b), .GAME_OVER(game_over), .HISCORE(hi_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a one-cycle request; returns just after the request edge.
  task automatic issue(input logic ra, input logic rb, input logic [1:0] p_a,
                       input logic [0:0] p_b, input logic [3:0] v);
    req_a = ra; req_b = rb; pa = p_a; pb = p_b; val = v;
    tick(1);
    req_a = 1'b0; req_b = 1'b0; val = 4'd0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_a || busy_b) && n < 40) begin
      tick(1);
      n++;
    end
    if (busy_a || busy_b) chk("idle_timeout", 64'(busy_a | busy_b), 64'd0);
  endtask

  task automatic add_both(input logic [1:0] p, input logic [3:0] v);
    issue(1'b1, 1'b1, p, p[0], v);
    wait_idle();
  endtask

  initial begin
    int ba, bb, wa, wb;
    logic [2:0] wrap_seen;
    rst_n = 1'b0; start_n = 1'b1; req_a = 1'b0; req_b = 1'b0; game_over = 1'b0;
    pa = '0; pb = '0; val = '0; sel_a = '0; sel_b = '0;

    // Reset state
    tick(2);
    chk("rst_scores_a", 64'(scores_a), 64'd0);
    chk("rst_scores_b", 64'(scores_b), 64'd0);
    chk("rst_busy_a",   64'(busy_a),   64'd0);
    chk("rst_wrap_a",   64'(wrap_a),   64'd0);
    chk("rst_hi_a",     64'(hi_a),     64'd0);
    rst_n = 1'b1;
    tick(1);

    // P0 += 7: busy for exactly 7 cycles
    issue(1'b1, 1'b1, 2'd0, 1'b0, 4'd7);
    chk("add7_busy_start", 64'(busy_a), 64'd1);
    tick(6);
    chk("add7_busy_last", 64'(busy_a), 64'd1);
    chk("add7_p0_mid",    64'(scores_a[11:0]), 64'h006);
    tick(1);
    chk("add7_busy_end",  64'(busy_a), 64'd0);
    chk("add7_scores_a",  64'(scores_a), 64'h000_000_007);
    chk("add7_scores_b",  64'(scores_b), 64'h000_007);

    // ADD_VAL = 0 and out-of-range player: no activity
    issue(1'b1, 1'b1, 2'd0, 1'b0, 4'd0);
    chk("val0_busy_a", 64'(busy_a), 64'd0);
    chk("val0_busy_b", 64'(busy_b), 64'd0);
    issue(1'b1, 1'b0, 2'd3, 1'b0, 4'd5);
    chk("badidx_busy", 64'(busy_a), 64'd0);
    tick(1);
    chk("badidx_scores", 64'(scores_a), 64'h000_000_007);

    // P1 to 095, then +8 with a request dropped mid-count
    for (int i = 0; i < 6; i++) add_both(2'd1, 4'd15);
    add_both(2'd1, 4'd5);
    chk("p1_095", 64'(scores_a[23:12]), 64'h095);
    issue(1'b1, 1'b1, 2'd1, 1'b1, 4'd8);
    wrap_seen = '0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) begin
        req_a = 1'b1; req_b = 1'b1; pa = 2'd0; pb = 1'b0; val = 4'd3;
      end
      tick(1);
      req_a = 1'b0; req_b = 1'b0; val = 4'd0;
      wrap_seen = wrap_seen | wrap_a;
    end
    chk("p1_100_mid", 64'(scores_a[23:12]), 64'h100);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      wrap_seen = wrap_seen | wrap_a;
    end
    chk("p1_103_busy", 64'(busy_a), 64'd0);
    chk("p1_103",      64'(scores_a[23:12]), 64'h103);
    chk("p1_no_wrap",  64'(wrap_seen), 64'd0);
    tick(2);
    chk("dropped_req_p0", 64'(scores_a[11:0]), 64'h007);
    chk("dropped_req_b",  64'(scores_b), 64'h103_007);

    // Display mux
    sel_a = 2'd1; sel_b = 1'b1;
    #1;
    chk("disp_a_p1", 64'(disp_a), 64'h103);
    chk("disp_b_p1", 64'(disp_b), 64'h103);
    sel_a = 2'd0;
    #1;
    chk("disp_a_p0", 64'(disp_a), 64'h007);
    sel_a = 2'd3;
    #1;
    chk("disp_a_oor", 64'(disp_a), 64'h000);

    // P0 to 995, then +7: wrap on dut_a, saturate on dut_b
    for (int i = 0; i < 65; i++) add_both(2'd0, 4'd15);
    add_both(2'd0, 4'd13);
    chk("p0_995_a", 64'(scores_a[11:0]), 64'h995);
    chk("p0_995_b", 64'(scores_b[11:0]), 64'h995);
    issue(1'b1, 1'b1, 2'd0, 1'b0, 4'd7);
    ba = 0; bb = 0; wa = 0; wb = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy_a) ba++;
      if (busy_b) bb++;
      if (wrap_a[0]) wa++;
      if (wrap_b[0]) wb++;
      tick(1);
    end
    chk("wrap_busy_a",   64'(ba), 64'd7);
    chk("sat_busy_b",    64'(bb), 64'd5);
    chk("wrap_pulses_a", 64'(wa), 64'd1);
    chk("sat_pulses_b",  64'(wb), 64'd1);
    chk("wrap_p0_a",     64'(scores_a[11:0]), 64'h002);
    chk("sat_p0_b",      64'(scores_b[11:0]), 64'h999);

    // START_GAME_N mid-count
    issue(1'b1, 1'b1, 2'd1, 1'b1, 4'd10);
    tick(3);
    start_n = 1'b0;
    tick(1);
    chk("clr_scores_a", 64'(scores_a), 64'd0);
    chk("clr_scores_b", 64'(scores_b), 64'd0);
    chk("clr_busy_a",   64'(busy_a),   64'd0);
    chk("clr_busy_b",   64'(busy_b),   64'd0);
    start_n = 1'b1;
    tick(2);
    chk("clr_stays_a",  64'(scores_a), 64'd0);
    chk("clr_idle_a",   64'(busy_a),   64'd0);

    // High score
    for (int i = 0; i < 8; i++) add_both(2'd0, 4'd15);
    for (int i = 0; i < 22; i++) add_both(2'd1, 4'd15);
    add_both(2'd1, 4'd10);
    chk("hs_scores_a", 64'(scores_a), 64'h000_340_120);
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    chk("hs_first_a", 64'(hi_a), 64'(EXP_HI));
    chk("hs_first_b", 64'(hi_b), 64'(EXP_HI));
    start_n = 1'b0;
    tick(1);
    start_n = 1'b1;
    chk("hs_kept_on_clr", 64'(hi_a), 64'(EXP_HI));
    for (int i = 0; i < 13; i++) add_both(2'd0, 4'd15);
    add_both(2'd0, 4'd5);
    chk("hs_p0_200", 64'(scores_a[11:0]), 64'h200);
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    chk("hs_second_a", 64'(hi_a), 64'(EXP_HI));
    chk("hs_second_b", 64'(hi_b), 64'(EXP_HI));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
